av_burst_master_p: RTL and testbench

Parametrised Avalon-MM burst master that moves one cache line between the cache/data-memory bus and an Avalon-MM slave (SDRAM controller).
- Generalises the fixed 512/32-bit line master: line width, Avalon data width, address width and burst depth are parameters.
- Adds: byteenable, partial bursts with clamping, latched request inputs, a done strobe, and a no-progress timeout with error reporting.
- Sits between the data cache miss/writeback logic and the Avalon interconnect.

---
 rtl/av_burst_master_p_if.sv | 59 +++++
 rtl/av_burst_master_p.sv | 189 ++++++++++++++++++
 tb/tb_av_burst_master_p.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/av_burst_master_p_if.sv
// av_burst_master_p_if
// Bundles the two sides of the line burst master:
//   - cache side: data_* request inputs, the line to write, the assembled
//     read line, and the busy / done / error status outputs;
//   - Avalon-MM side: av_* command, data and handshake signals.
// Modports:
//   master : the burst master's own view (drives av_* commands and data_*_out)
//   slave  : the environment's view (cache requester plus Avalon slave)
// Handshake rules: a write beat transfers on a cycle with av_write high and
// av_waitrequest low; a read command transfers on av_read high with
// av_waitrequest low; read beats transfer on every cycle with
// av_readdatavalid high.
interface av_burst_master_p_if #(
    parameter int LINE_WIDTH    = 512,
    parameter int AV_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH    = 32
);
    localparam int BEATS = LINE_WIDTH / AV_DATA_WIDTH;
    localparam int BC_W  = $clog2(BEATS) + 1;

    // cache side
    logic [ADDR_WIDTH-1:0]      data_address_in;
    logic                       data_read_in;
    logic                       data_write_in;
    logic [LINE_WIDTH-1:0]      data_write_value_in;
    logic [BC_W-1:0]            burstcount_in;
    logic                       data_wait_out;
    logic                       data_done_out;
    logic                       data_error_out;
    logic [LINE_WIDTH-1:0]      data_read_value_out;

    // Avalon-MM side
    logic [ADDR_WIDTH-1:0]      av_address;
    logic                       av_read;
    logic                       av_write;
    logic                       av_waitrequest;
    logic [AV_DATA_WIDTH-1:0]   av_readdata;
    logic                       av_readdatavalid;
    logic [AV_DATA_WIDTH-1:0]   av_writedata;
    logic [AV_DATA_WIDTH/8-1:0] av_byteenable;
    logic [BC_W-1:0]            av_burstcount;
    logic                       av_beginbursttransfer;

    modport master (
        input  data_address_in, data_read_in, data_write_in, data_write_value_in,
               burstcount_in, av_waitrequest, av_readdata, av_readdatavalid,
        output data_wait_out, data_done_out, data_error_out, data_read_value_out,
               av_address, av_read, av_write, av_writedata, av_byteenable,
               av_burstcount, av_beginbursttransfer
    );

    modport slave (
        output data_address_in, data_read_in, data_write_in, data_write_value_in,
               burstcount_in, av_waitrequest, av_readdata, av_readdatavalid,
        input  data_wait_out, data_done_out, data_error_out, data_read_value_out,
               av_address, av_read, av_write, av_writedata, av_byteenable,
               av_burstcount, av_beginbursttransfer
    );
endinterface

// File: rtl/av_burst_master_p.sv
// av_burst_master_p
// Moves one cache line between the cache bus and an Avalon-MM burst slave.
// A request is latched in IDLE (write wins over read), the burst count is
// clamped to 1..BEATS, and the burst is issued one cycle later. A run of
// TIMEOUT_CYCLES cycles without progress aborts the transfer and raises
// data_error_out together with data_done_out.
// Ports:
//   clk         : clock
//   clr         : asynchronous reset, active high
//   bus         : av_burst_master_p_if.master (cache side + Avalon side)
//   o_dbg_state : current FSM state, for observation only
module av_burst_master_p #(
    parameter int LINE_WIDTH     = 512,
    parameter int AV_DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    clr,
    av_burst_master_p_if.master     bus,
    output logic [2:0]              o_dbg_state
);
    localparam int BEATS  = LINE_WIDTH / AV_DATA_WIDTH;
    localparam int BC_W   = $clog2(BEATS) + 1;
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(BEATS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_CMD  = 3'd2,
        S_RD_DATA = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wline;
    logic [LINE_WIDTH-1:0]   r_rline;
    logic [BC_W-1:0]         r_ebc;
    logic [BC_W-1:0]         r_cnt;
    logic [TO_W-1:0]         r_tcnt;
    logic                    r_av_read;
    logic                    r_av_write;
    logic                    r_begin;
    logic                    r_wait;
    logic                    r_done;
    logic                    r_err;

    logic [BC_W-1:0]         w_ebc;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_last;
    logic                    w_timeout;

    // Zero or an oversize request means "whole line".
    always_comb begin
        w_ebc = bus.burstcount_in;
        if (bus.burstcount_in == '0 || bus.burstcount_in > BC_FULL)
            w_ebc = BC_FULL;
    end

    assign w_idx     = r_cnt[IDX_W-1:0];
    assign w_last    = (r_cnt == r_ebc - 1'b1);
    // The counter holds the number of stalled cycles already seen, so the
    // abort fires on the TIMEOUT_CYCLES-th stalled cycle.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_tcnt == TO_W'(TO_MAX));

    assign bus.av_address            = r_addr;
    assign bus.av_burstcount         = r_ebc;
    assign bus.av_read               = r_av_read;
    assign bus.av_write              = r_av_write;
    assign bus.av_beginbursttransfer = r_begin;
    assign bus.av_writedata          = r_wline[w_idx*AV_DATA_WIDTH +: AV_DATA_WIDTH];
    assign bus.av_byteenable         = (r_av_read || r_av_write) ? '1 : '0;
    assign bus.data_wait_out         = r_wait;
    assign bus.data_done_out         = r_done;
    assign bus.data_error_out        = r_err;
    assign bus.data_read_value_out   = r_rline;
    assign o_dbg_state               = r_state;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wline    <= '0;
            r_rline    <= '0;
            r_ebc      <= '0;
            r_cnt      <= '0;
            r_tcnt     <= '0;
            r_av_read  <= 1'b0;
            r_av_write <= 1'b0;
            r_begin    <= 1'b0;
            r_wait     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Strobes last one cycle; the begin marker only covers the first
            // command cycle, stalled or not.
            r_begin <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.data_write_in || bus.data_read_in) begin
                        r_addr  <= bus.data_address_in;
                        r_wline <= bus.data_write_value_in;
                        r_ebc   <= w_ebc;
                        r_cnt   <= '0;
                        r_tcnt  <= '0;
                        r_wait  <= 1'b1;
                        r_begin <= 1'b1;
                        if (bus.data_write_in) begin
                            r_av_write <= 1'b1;
                            r_state    <= S_WR;
                        end else begin
                            r_rline    <= '0;
                            r_av_read  <= 1'b1;
                            r_state    <= S_RD_CMD;
                        end
                    end
                end
                S_WR: begin
                    if (!bus.av_waitrequest) begin
                        r_tcnt <= '0;
                        if (w_last) begin
                            r_av_write <= 1'b0;
                            r_wait     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_av_write <= 1'b0;
                        r_wait     <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_RD_CMD: begin
                    if (!bus.av_waitrequest) begin
                        r_tcnt    <= '0;
                        r_av_read <= 1'b0;
                        r_state   <= S_RD_DATA;
                    end else if (w_timeout) begin
                        r_av_read <= 1'b0;
                        r_wait    <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (bus.av_readdatavalid) begin
                        r_tcnt <= '0;
                        r_rline[w_idx*AV_DATA_WIDTH +: AV_DATA_WIDTH] <= bus.av_readdata;
                        if (w_last) begin
                            r_wait  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_wait  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_av_burst_master_p.sv
// Bench for av_burst_master_p: drives cache requests and an Avalon slave
// model cycle by cycle, and checks against a line-level reference model.
module tb_av_burst_master_p;
    localparam int LINE_W = 512;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int TO     = 8;
    localparam int BC_W   = 5;
    localparam int BUDGET = 400;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    av_burst_master_p_if #(.LINE_WIDTH(LINE_W), .AV_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    av_burst_master_p #(
        .LINE_WIDTH(LINE_W), .AV_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .clr(clr), .bus(bus), .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard / observations ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0]     exp_q[$];
    logic [DW-1:0]     got_q[$];
    logic [DW-1:0]     rd_vals[16];
    logic [LINE_W-1:0] last_read_line;

    int obs_cmd_cycles, obs_begin_cnt, obs_begin_bad, obs_attr_bad, obs_hold_bad;
    int obs_gap_bad, obs_wait_bad, obs_other_cmd, obs_done_cyc, obs_last_rdv_cyc;
    bit obs_done_seen, obs_done_err, obs_done_wait, obs_idle_ok;

    // ---------------- reference model ----------------
    function automatic int ebc_model(input int bc);
        return (bc < 1 || bc > 16) ? 16 : bc;
    endfunction

    function automatic logic [LINE_W-1:0] read_line_model(input int n_valid);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int i = 0; i < 16; i++)
            if (i < n_valid) l[i*DW +: DW] = rd_vals[i];
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 16; i++) l[i*DW +: DW] = $urandom;
        return l;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        obs_cmd_cycles = 0; obs_begin_cnt = 0; obs_begin_bad = 0; obs_attr_bad = 0;
        obs_hold_bad = 0; obs_gap_bad = 0; obs_wait_bad = 0; obs_other_cmd = 0;
        obs_done_cyc = -1; obs_last_rdv_cyc = -1;
        obs_done_seen = 0; obs_done_err = 0; obs_done_wait = 0; obs_idle_ok = 0;
        got_q.delete();
    endtask

    // Records status at the done strobe and the bus state one cycle later.
    task automatic watch_done(input int cyc, output bit stop);
        stop = 0;
        if (obs_done_seen && cyc == obs_done_cyc + 1) begin
            obs_idle_ok = !bus.data_wait_out && !bus.av_write && !bus.av_read &&
                          !bus.data_done_out && !bus.data_error_out;
            stop = 1;
        end else if (bus.data_done_out && !obs_done_seen) begin
            obs_done_seen = 1; obs_done_cyc = cyc;
            obs_done_err = bus.data_error_out; obs_done_wait = bus.data_wait_out;
        end else if (!obs_done_seen && !bus.data_wait_out) begin
            obs_wait_bad++;
        end
    endtask

    // Beat k is stalled for stall_len cycles when stall_mask[k] is set.
    task automatic drive_write(input logic [AW-1:0] addr, input logic [LINE_W-1:0] line,
                               input int bc, input logic [15:0] stall_mask,
                               input int stall_len, input bit also_read);
        int stalls, accepted, exp_bc;
        bit wr, prev_stalled, stop;
        logic [DW-1:0] prev_data;
        clear_obs();
        exp_bc = ebc_model(bc);
        @(negedge clk);
        bus.data_address_in = addr; bus.data_write_value_in = line;
        bus.burstcount_in = BC_W'(bc); bus.data_write_in = 1'b1; bus.data_read_in = also_read;
        @(negedge clk);
        bus.data_write_in = 1'b0; bus.data_read_in = 1'b0;
        stalls = 0; accepted = 0; prev_stalled = 0; prev_data = '0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            wr = 0;
            if (bus.av_read) obs_other_cmd++;
            if (bus.av_write) begin
                if (cyc != obs_cmd_cycles) obs_gap_bad++;
                obs_cmd_cycles++;
                if (bus.av_beginbursttransfer) begin
                    obs_begin_cnt++;
                    if (obs_cmd_cycles != 1) obs_begin_bad++;
                end
                if (bus.av_address !== addr || bus.av_burstcount !== BC_W'(exp_bc) ||
                    bus.av_byteenable !== 4'hF) obs_attr_bad++;
                if (prev_stalled && bus.av_writedata !== prev_data) obs_hold_bad++;
                if (accepted < 16 && stall_mask[accepted] && stalls < stall_len) begin
                    wr = 1; stalls++;
                end else begin
                    got_q.push_back(bus.av_writedata); accepted++; stalls = 0;
                end
                prev_stalled = wr; prev_data = bus.av_writedata;
            end else if (bus.av_byteenable !== 4'h0 || bus.av_beginbursttransfer) begin
                obs_attr_bad++;
            end
            bus.av_waitrequest = wr;
            watch_done(cyc, stop);
            if (stop) break;
            @(negedge clk);
        end
        bus.av_waitrequest = 1'b0;
    endtask

    // Read slave: stalls the command cmd_stall cycles, then returns
    // n_supply beats from rd_vals with gap idle cycles before each one.
    task automatic drive_read(input logic [AW-1:0] addr, input int bc, input int cmd_stall,
                              input int gap, input int n_supply, input bit junk_rdv);
        int stalls, supplied, gap_left, exp_bc;
        bit wr, rdv, data_phase, go_data, stop;
        logic [DW-1:0] rdata;
        clear_obs();
        exp_bc = ebc_model(bc);
        @(negedge clk);
        bus.data_address_in = addr; bus.burstcount_in = BC_W'(bc); bus.data_read_in = 1'b1;
        @(negedge clk);
        bus.data_read_in = 1'b0;
        stalls = 0; supplied = 0; gap_left = gap; data_phase = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            wr = 0; rdv = 0; rdata = $urandom; go_data = 0;
            if (bus.av_write) obs_other_cmd++;
            if (data_phase) begin
                if (supplied < n_supply && gap_left == 0) begin
                    rdv = 1; rdata = rd_vals[supplied]; supplied++; gap_left = gap;
                    obs_last_rdv_cyc = cyc;
                end else if (gap_left > 0) begin
                    gap_left--;
                end
            end
            if (bus.av_read) begin
                if (cyc != obs_cmd_cycles) obs_gap_bad++;
                obs_cmd_cycles++;
                if (bus.av_beginbursttransfer) begin
                    obs_begin_cnt++;
                    if (obs_cmd_cycles != 1) obs_begin_bad++;
                end
                if (bus.av_address !== addr || bus.av_burstcount !== BC_W'(exp_bc) ||
                    bus.av_byteenable !== 4'hF) obs_attr_bad++;
                if (stalls < cmd_stall) begin wr = 1; stalls++; end
                else go_data = 1;
                if (junk_rdv) rdv = 1;
            end else if (bus.av_byteenable !== 4'h0 || bus.av_beginbursttransfer) begin
                obs_attr_bad++;
            end
            bus.av_waitrequest = wr; bus.av_readdatavalid = rdv; bus.av_readdata = rdata;
            if (go_data) data_phase = 1;
            watch_done(cyc, stop);
            if (stop) break;
            @(negedge clk);
        end
        bus.av_waitrequest = 1'b0; bus.av_readdatavalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.data_wait_out, bus.data_done_out, bus.data_error_out, bus.av_read, bus.av_write,
             bus.av_beginbursttransfer, bus.av_byteenable, bus.av_burstcount, bus.av_address,
             bus.av_writedata} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs, required all zero");
        else n_pass++;
        n_total++;
        if (bus.data_read_value_out !== '0 || dbg_state !== 3'd0)
            $display("FAIL reset_line_state: line %0h state %0d, required 0/IDLE",
                     bus.data_read_value_out, dbg_state);
        else n_pass++;
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_write();
        logic [LINE_W-1:0] line;
        logic [DW-1:0] e, g;
        for (int i = 0; i < 16; i++) line[i*DW +: DW] = 32'h100 + i;
        for (int i = 0; i < 16; i++) exp_q.push_back(line[i*DW +: DW]);
        drive_write(32'h0000_4000, line, 16, 16'h0000, 0, 0);
        n_total++;
        if (got_q.size() != exp_q.size())
            $display("FAIL fw_beats: got %0d beats, required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL fw_data: got %0h required %0h", g, e); else n_pass++;
        end
        exp_q.delete();
        n_total++;
        if (obs_cmd_cycles != 16 || obs_gap_bad != 0)
            $display("FAIL fw_write_cycles: got %0d (gaps %0d), required 16 contiguous",
                     obs_cmd_cycles, obs_gap_bad);
        else n_pass++;
        n_total++;
        if (obs_begin_cnt != 1 || obs_begin_bad != 0)
            $display("FAIL fw_begin: got %0d markers, required 1 in first cycle", obs_begin_cnt);
        else n_pass++;
        n_total++;
        if (!obs_done_seen || obs_done_cyc != 16 || obs_done_wait || obs_done_err)
            $display("FAIL fw_done: seen %0d cyc %0d wait %0d err %0d, required 1/16/0/0",
                     obs_done_seen, obs_done_cyc, obs_done_wait, obs_done_err);
        else n_pass++;
        n_total++;
        if (!obs_idle_ok || obs_attr_bad != 0 || obs_wait_bad != 0)
            $display("FAIL fw_idle_attr: idle %0d attr %0d wait %0d, required 1/0/0",
                     obs_idle_ok, obs_attr_bad, obs_wait_bad);
        else n_pass++;
    endtask

    task automatic test_write_stall();
        logic [LINE_W-1:0] line;
        logic [DW-1:0] e, g;
        line = rand_line();
        for (int i = 0; i < 16; i++) exp_q.push_back(line[i*DW +: DW]);
        drive_write(32'h0000_8040, line, 16, 16'h0081, 3, 0);
        n_total++;
        if (got_q.size() != 16)
            $display("FAIL ws_beats: got %0d beats, required 16", got_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_total++;
            if (g !== e) $display("FAIL ws_data: got %0h required %0h", g, e); else n_pass++;
        end
        exp_q.delete();
        n_total++;
        if (obs_cmd_cycles != 22)
            $display("FAIL ws_write_cycles: got %0d, required 22", obs_cmd_cycles);
        else n_pass++;
        n_total++;
        if (obs_hold_bad != 0 || obs_attr_bad != 0)
            $display("FAIL ws_hold: data moves %0d attr changes %0d, required 0/0",
                     obs_hold_bad, obs_attr_bad);
        else n_pass++;
        n_total++;
        if (!obs_done_seen || obs_done_cyc != 22 || obs_done_err)
            $display("FAIL ws_done: seen %0d cyc %0d err %0d, required 1/22/0",
                     obs_done_seen, obs_done_cyc, obs_done_err);
        else n_pass++;
    endtask

    task automatic test_read_partial();
        logic [LINE_W-1:0] exp_line;
        for (int i = 0; i < 16; i++) rd_vals[i] = (i < 4) ? 32'hA0 + i : $urandom | 32'h1;
        drive_read(32'h0001_0000, 4, 0, 2, 4, 0);
        exp_line = read_line_model(4);
        last_read_line = exp_line;
        n_total++;
        if (bus.data_read_value_out !== exp_line)
            $display("FAIL rp_line: got %0h required %0h", bus.data_read_value_out, exp_line);
        else n_pass++;
        n_total++;
        if (obs_cmd_cycles != 1 || obs_begin_cnt != 1 || obs_attr_bad != 0)
            $display("FAIL rp_cmd: read cycles %0d begin %0d attr %0d, required 1/1/0",
                     obs_cmd_cycles, obs_begin_cnt, obs_attr_bad);
        else n_pass++;
        n_total++;
        if (!obs_done_seen || obs_done_cyc != obs_last_rdv_cyc + 1 || obs_done_err || !obs_idle_ok)
            $display("FAIL rp_done: seen %0d cyc %0d last beat %0d err %0d idle %0d",
                     obs_done_seen, obs_done_cyc, obs_last_rdv_cyc, obs_done_err, obs_idle_ok);
        else n_pass++;
    endtask

    task automatic test_burst_clamp();
        logic [LINE_W-1:0] line;
        line = rand_line();
        drive_write(32'h0000_0100, line, 0, 16'h0000, 0, 0);
        n_total++;
        if (obs_attr_bad != 0 || obs_cmd_cycles != 16 || got_q.size() != 16)
            $display("FAIL clamp_bc0: attr %0d cycles %0d beats %0d, required 0/16/16",
                     obs_attr_bad, obs_cmd_cycles, got_q.size());
        else n_pass++;
        for (int i = 0; i < 16; i++) rd_vals[i] = $urandom;
        drive_read(32'h0000_0200, 31, 0, 0, 16, 0);
        last_read_line = read_line_model(16);
        n_total++;
        if (obs_attr_bad != 0 || bus.data_read_value_out !== last_read_line)
            $display("FAIL clamp_bc31: attr %0d line %0h required %0h", obs_attr_bad,
                     bus.data_read_value_out, last_read_line);
        else n_pass++;
    endtask

    task automatic test_timeout_write();
        drive_write(32'h0000_0300, rand_line(), 16, 16'h0001, 1000, 0);
        n_total++;
        if (obs_cmd_cycles != TO || got_q.size() != 0)
            $display("FAIL to_wr_cycles: got %0d cycles %0d beats, required %0d/0",
                     obs_cmd_cycles, got_q.size(), TO);
        else n_pass++;
        n_total++;
        if (!obs_done_seen || !obs_done_err || obs_done_cyc != TO || !obs_idle_ok)
            $display("FAIL to_wr_done: seen %0d err %0d cyc %0d idle %0d, required 1/1/%0d/1",
                     obs_done_seen, obs_done_err, obs_done_cyc, obs_idle_ok, TO);
        else n_pass++;
    endtask

    task automatic test_timeout_read();
        for (int i = 0; i < 16; i++) rd_vals[i] = $urandom;
        drive_read(32'h0000_0400, 4, 0, 0, 2, 0);
        last_read_line = read_line_model(2);
        n_total++;
        if (!obs_done_seen || !obs_done_err || obs_done_cyc != obs_last_rdv_cyc + TO + 1)
            $display("FAIL to_rd_done: seen %0d err %0d cyc %0d, required 1/1/%0d",
                     obs_done_seen, obs_done_err, obs_done_cyc, obs_last_rdv_cyc + TO + 1);
        else n_pass++;
        n_total++;
        if (bus.data_read_value_out !== last_read_line)
            $display("FAIL to_rd_line: got %0h required %0h", bus.data_read_value_out,
                     last_read_line);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [LINE_W-1:0] line;
        line = rand_line();
        drive_write(32'h0000_0500, line, 8, 16'h0000, 0, 1);
        n_total++;
        if (obs_other_cmd != 0 || obs_cmd_cycles != 8 || got_q.size() != 8)
            $display("FAIL simul_write_first: reads %0d writes %0d beats %0d, required 0/8/8",
                     obs_other_cmd, obs_cmd_cycles, got_q.size());
        else n_pass++;
        n_total++;
        if (got_q.size() == 8 && got_q[7] !== line[7*DW +: DW])
            $display("FAIL simul_last_beat: got %0h required %0h", got_q[7], line[7*DW +: DW]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [LINE_W-1:0] line;
        logic [DW-1:0] e, g;
        logic [15:0] mask;
        int bc, eb, sl, cs, gp, exp_cycles, errs;
        for (int t = 0; t < 12; t++) begin
            bc = $urandom_range(0, 31);
            eb = ebc_model(bc);
            if ($urandom_range(0, 1) == 1) begin
                line = rand_line(); mask = 16'($urandom); sl = $urandom_range(0, 3);
                for (int i = 0; i < eb; i++) exp_q.push_back(line[i*DW +: DW]);
                exp_cycles = eb;
                for (int i = 0; i < eb; i++) if (mask[i]) exp_cycles += sl;
                drive_write($urandom, line, bc, mask, sl, 0);
                errs = 0;
                if (got_q.size() != exp_q.size()) errs++;
                while (exp_q.size() > 0 && got_q.size() > 0) begin
                    e = exp_q.pop_front(); g = got_q.pop_front();
                    if (g !== e) errs++;
                end
                exp_q.delete();
                n_total++;
                if (errs != 0) $display("FAIL rnd_wr_data: %0d beat errors, required 0", errs);
                else n_pass++;
                n_total++;
                if (obs_cmd_cycles != exp_cycles || obs_done_cyc != exp_cycles || obs_done_err ||
                    obs_hold_bad != 0 || obs_attr_bad != 0)
                    $display("FAIL rnd_wr_timing: cycles %0d done %0d required %0d err %0d hold %0d attr %0d",
                             obs_cmd_cycles, obs_done_cyc, exp_cycles, obs_done_err,
                             obs_hold_bad, obs_attr_bad);
                else n_pass++;
                n_total++;
                if (bus.data_read_value_out !== last_read_line)
                    $display("FAIL rnd_read_hold: got %0h required %0h",
                             bus.data_read_value_out, last_read_line);
                else n_pass++;
            end else begin
                for (int i = 0; i < 16; i++) rd_vals[i] = $urandom;
                cs = $urandom_range(0, 3); gp = $urandom_range(0, 3);
                drive_read($urandom, bc, cs, gp, eb, 1'($urandom_range(0, 1)));
                last_read_line = read_line_model(eb);
                n_total++;
                if (bus.data_read_value_out !== last_read_line)
                    $display("FAIL rnd_rd_line: got %0h required %0h",
                             bus.data_read_value_out, last_read_line);
                else n_pass++;
                n_total++;
                if (obs_cmd_cycles != cs + 1 || obs_done_cyc != obs_last_rdv_cyc + 1 ||
                    obs_done_err || obs_attr_bad != 0 || obs_wait_bad != 0)
                    $display("FAIL rnd_rd_timing: cmd %0d required %0d done %0d last %0d err %0d attr %0d",
                             obs_cmd_cycles, cs + 1, obs_done_cyc, obs_last_rdv_cyc,
                             obs_done_err, obs_attr_bad);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clr_mid_read();
        int strobes;
        @(negedge clk);
        bus.data_address_in = 32'h0000_0600; bus.burstcount_in = 5'd16; bus.data_read_in = 1'b1;
        @(negedge clk);
        bus.data_read_in = 1'b0; bus.av_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.av_readdatavalid = 1'b1; bus.av_readdata = 32'hC0DE_0000 + i;
        end
        @(negedge clk);
        bus.av_readdatavalid = 1'b0;
        #2 clr = 1'b1;
        #1;
        n_total++;
        if ({bus.data_wait_out, bus.data_done_out, bus.data_error_out, bus.av_read, bus.av_write,
             bus.av_beginbursttransfer, bus.av_byteenable, bus.av_burstcount, bus.av_address,
             bus.av_writedata} !== '0 || bus.data_read_value_out !== '0)
            $display("FAIL clr_async: outputs not zero right after clr (wait %0d line %0h)",
                     bus.data_wait_out, bus.data_read_value_out);
        else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.data_done_out || bus.data_error_out || bus.data_wait_out) strobes++;
        end
        last_read_line = '0;
        n_total++;
        if (strobes != 0)
            $display("FAIL clr_no_done: got %0d busy/strobe cycles, required 0", strobes);
        else n_pass++;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        bus.data_address_in = '0; bus.data_read_in = 1'b0; bus.data_write_in = 1'b0;
        bus.data_write_value_in = '0; bus.burstcount_in = '0; bus.av_waitrequest = 1'b0;
        bus.av_readdata = '0; bus.av_readdatavalid = 1'b0;
        last_read_line = '0;
        test_reset();
        test_full_write();
        test_write_stall();
        test_read_partial();
        test_burst_clamp();
        test_timeout_write();
        test_timeout_read();
        test_simultaneous();
        test_random();
        test_clr_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
